uart_wb_host: RTL and testbench
===============================

// Module: uart_wb_host
// PURPOSE
//  Wishbone initiator that issues single register read/write cycles to the UART register file.
//  It converts a valid/ready command stream into one classic Wishbone cycle per command.
//  It returns read data and status on a valid/ready response stream.
//  It also tracks the UART interrupt line for the host side of the UART subsystem.
// PARAMETERS
//  SEL_VAL         4'b0001  constant byte-select driven on sel_out during a cycle
//  TIMEOUT_CYCLES  16       cycles in BUS without ack before abort (UART_WB_TIMEOUT_EN only); >=1
// PORTS
//  clk             in   1  single clock; all logic on posedge
//  rst_in          in   1  asynchronous, active-low reset
//  cmd_valid_in    in   1  command present
//  cmd_ready_out   out  1  command accepted when valid&ready
//  cmd_we_in       in   1  1=write, 0=read
//  cmd_addr_in     in   3  UART register address
//  cmd_wdata_in    in   8  write data
//  rsp_valid_out   out  1  response present
//  rsp_ready_in    in   1  response consumed when valid&ready
//  rsp_rdata_out   out  8  read data (0 for writes and errors)
//  rsp_err_out     out  1  1=cycle aborted by timeout
//  addr_out        out  3  Wishbone address
//  data_out        out  8  Wishbone write data
//  data_in         in   8  Wishbone read data
//  sel_out         out  4  Wishbone byte select
//  stb_out         out  1  Wishbone strobe
//  cyc_out         out  1  Wishbone cycle
//  wr_enb_out      out  1  Wishbone write enable
//  ack_in          in   1  Wishbone acknowledge
//  int_in          in   1  UART interrupt, level, clk domain
//  irq_pending_out out  1  registered int_in
//  irq_count_out   out  8  saturating count of int_in rising edges
// BEHAVIOUR
//  Reset:
//   - All outputs are 0 and state is IDLE, asynchronously on rst_in low.
//   - A reset mid-cycle drops stb_out/cyc_out immediately and loses the pending command.
//  FSM:
//   - IDLE: cmd_ready_out=1. On cmd_valid_in, register we/addr/wdata and go to BUS.
//   - BUS: stb_out=cyc_out=1, sel_out=SEL_VAL; addr_out, data_out and wr_enb_out hold the registered command.
//     - On ack_in: capture data_in into rsp_rdata_out if read (0 if write), set rsp_err_out=0, go to RESP.
//     - On the next edge, stb_out and cyc_out are 0.
//   - RESP: rsp_valid_out=1; the response is held stable until rsp_ready_in, then go to IDLE.
//  Latency:
//   - Command accepted at edge N; stb_out is high after N.
//   - ack_in sampled at edge M; rsp_valid_out is high after M.
//   - Zero-wait ack gives M=N+1.
//  Boundary conditions:
//   - Only one command is outstanding; cmd_ready_out is 0 in BUS and RESP.
//   - When rsp_ready_in is already high, rsp_valid_out lasts exactly 1 cycle; cmd_ready_out rises on the following cycle.
//   - ack_in outside BUS is ignored.
//   - addr_out, data_out and wr_enb_out are 0 when not in BUS.
//  Interrupt:
//   - irq_pending_out <= int_in each cycle.
//   - irq_count_out increments when int_in=1 && irq_pending_out=0, and saturates at 255.
//   - The interrupt logic is independent of the FSM.
// CONFIGURATION
//  UART_WB_TIMEOUT_EN defined:
//   - An 8-bit wait counter clears on entry to BUS and counts in BUS.
//   - When it reaches TIMEOUT_CYCLES without ack: drop stb_out/cyc_out, go to RESP with rsp_err_out=1 and rsp_rdata_out=0.
//   - An ack on the same edge as the timeout wins (normal response).
//  Undefined:
//   - BUS waits indefinitely, rsp_err_out is tied 0 and there is no counter logic.
// STRUCTURE
//  Package uart_wb_pkg:
//   - state enum {IDLE,BUS,RESP}.
//   - Register addresses: RBR_THR=0, IER=1, IIR_FCR=2, LCR=3, MCR=4, LSR=5, MSR=6, SCR=7.
//   - Command/response struct typedefs.
//  Optional sub-module uart_wb_timeout: counter plus expiry flag, instantiated only under UART_WB_TIMEOUT_EN.
// TESTING
//  1. Write LCR=8'h83, ack 1 cycle after stb:
//     -> stb/cyc high exactly 1 cycle, addr=3, data=8'h83, we=1, sel=4'b0001; rsp err=0, rdata=0.
//  2. Read LSR with ack after 3 wait cycles, data_in=8'h60:
//     -> stb held 4 cycles, rsp_rdata=8'h60, rsp_valid 1 cycle after ack.
//  3. Back-to-back commands with rsp_ready_in held 0 for 5 cycles:
//     -> rsp held stable; cmd_ready stays 0 and no second cycle starts until the response is consumed.
//  4. Assert rst_in low while in BUS:
//     -> stb/cyc/rsp_valid 0 immediately; after release, cmd_ready=1 and no response is produced.
//  5. Toggle int_in high 3 times, then hold it high 10 cycles:
//     -> irq_count=3 and irq_pending follows with 1-cycle delay.
//  6. UART_WB_TIMEOUT_EN, TIMEOUT_CYCLES=16, never ack:
//     -> stb drops after 16 BUS cycles, rsp_err=1, rdata=0; a late ack_in is ignored.

Source files
------------

// File: rtl/uart_wb_pkg.sv
// uart_wb_pkg: shared types and constants for the UART Wishbone host slice.
//   state_t - host FSM states (IDLE, BUS, RESP)
//   RBR_THR..SCR - UART register addresses on the 3-bit Wishbone address bus
//   cmd_t   - one register command (write enable, address, write data)
//   rsp_t   - one register response (read data, timeout error)
package uart_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] RBR_THR = 3'd0;
  localparam logic [2:0] IER     = 3'd1;
  localparam logic [2:0] IIR_FCR = 3'd2;
  localparam logic [2:0] LCR     = 3'd3;
  localparam logic [2:0] MCR     = 3'd4;
  localparam logic [2:0] LSR     = 3'd5;
  localparam logic [2:0] MSR     = 3'd6;
  localparam logic [2:0] SCR     = 3'd7;

  typedef struct packed {
    logic       we;
    logic [2:0] addr;
    logic [7:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic [7:0] rdata;
    logic       err;
  } rsp_t;

endpackage

// File: rtl/uart_wb_timeout.sv
// uart_wb_timeout: bus wait counter with expiry flag for the UART Wishbone host.
// Only instantiated when UART_WB_TIMEOUT_EN is defined.
// Ports:
//   clk     - clock, posedge
//   rst_in  - asynchronous active-low reset
//   clear   - command accepted this cycle; restart the count for the new cycle
//   run     - host is in its BUS state
//   expired - run is high and TIMEOUT_CYCLES BUS cycles have elapsed at this edge
module uart_wb_timeout
  import uart_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_in,
  input  logic clear,
  input  logic run,
  output logic expired
);

  // The count is 0 during the first BUS cycle, so it equals LIMIT during
  // the TIMEOUT_CYCLES-th BUS cycle, which is the edge that aborts.
  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] count;

  assign expired = run && (count == LIMIT);

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run && !expired) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/uart_wb_host.sv
// uart_wb_host: Wishbone initiator issuing single classic read/write cycles to
// the UART register file, one per accepted command, and returning read data /
// status on a response stream. Also tracks the UART interrupt line.
// Optional feature macro: UART_WB_TIMEOUT_EN (abort a BUS cycle after
// TIMEOUT_CYCLES cycles without ack and report rsp_err_out=1).
// Ports:
//   clk, rst_in                 - clock (posedge), asynchronous active-low reset
//   cmd_valid_in/cmd_ready_out  - command handshake
//   cmd_we_in/addr_in/wdata_in  - command: write enable, register address, write data
//   rsp_valid_out/rsp_ready_in  - response handshake
//   rsp_rdata_out/rsp_err_out   - response: read data, timeout error
//   addr_out/data_out/data_in   - Wishbone address, write data, read data
//   sel_out/stb_out/cyc_out     - Wishbone byte select, strobe, cycle
//   wr_enb_out/ack_in           - Wishbone write enable, acknowledge
//   int_in                      - UART interrupt level
//   irq_pending_out             - int_in registered
//   irq_count_out               - saturating count of int_in rising edges
module uart_wb_host
  import uart_wb_pkg::*;
#(
  parameter logic [3:0]  SEL_VAL        = 4'b0001,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_in,
  input  logic       cmd_valid_in,
  output logic       cmd_ready_out,
  input  logic       cmd_we_in,
  input  logic [2:0] cmd_addr_in,
  input  logic [7:0] cmd_wdata_in,
  output logic       rsp_valid_out,
  input  logic       rsp_ready_in,
  output logic [7:0] rsp_rdata_out,
  output logic       rsp_err_out,
  output logic [2:0] addr_out,
  output logic [7:0] data_out,
  input  logic [7:0] data_in,
  output logic [3:0] sel_out,
  output logic       stb_out,
  output logic       cyc_out,
  output logic       wr_enb_out,
  input  logic       ack_in,
  input  logic       int_in,
  output logic       irq_pending_out,
  output logic [7:0] irq_count_out
);

  state_t     state;
  cmd_t       cmd_q;
  logic [7:0] rdata_q;
  logic       in_bus;
  logic       in_resp;
  logic       accept;
  logic       timed_out;

  assign in_bus  = (state == BUS);
  assign in_resp = (state == RESP);
  assign accept  = cmd_valid_in && cmd_ready_out;

`ifdef UART_WB_TIMEOUT_EN
  logic expired;
  logic err_q;

  uart_wb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_in (rst_in),
    .clear  (accept),
    .run    (in_bus),
    .expired(expired)
  );

  // An ack arriving on the expiry edge takes priority: normal completion.
  assign timed_out = expired && !ack_in;

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      err_q <= 1'b0;
    end else if (in_bus) begin
      if (ack_in) begin
        err_q <= 1'b0;
      end else if (timed_out) begin
        err_q <= 1'b1;
      end
    end
  end

  assign rsp_err_out = in_resp && err_q;
`else
  assign timed_out   = 1'b0;
  assign rsp_err_out = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state   <= IDLE;
      cmd_q   <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_in) begin
            cmd_q <= '{we: cmd_we_in, addr: cmd_addr_in, wdata: cmd_wdata_in};
            state <= BUS;
          end
        end
        BUS: begin
          if (ack_in) begin
            rdata_q <= cmd_q.we ? 8'h00 : data_in;
            state   <= RESP;
          end else if (timed_out) begin
            rdata_q <= 8'h00;
            state   <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_in) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The FSM already sits in IDLE while reset is held; gating with rst_in keeps
  // cmd_ready_out low for the whole reset like every other output.
  assign cmd_ready_out = (state == IDLE) && rst_in;

  assign stb_out    = in_bus;
  assign cyc_out    = in_bus;
  assign sel_out    = in_bus ? SEL_VAL : '0;
  assign addr_out   = in_bus ? cmd_q.addr : '0;
  assign data_out   = in_bus ? cmd_q.wdata : '0;
  assign wr_enb_out = in_bus && cmd_q.we;

  assign rsp_valid_out = in_resp;
  assign rsp_rdata_out = in_resp ? rdata_q : '0;

  // Interrupt tracking runs regardless of the bus FSM.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      irq_pending_out <= 1'b0;
      irq_count_out   <= '0;
    end else begin
      irq_pending_out <= int_in;
      if (int_in && !irq_pending_out && (irq_count_out != 8'hFF)) begin
        irq_count_out <= irq_count_out + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_wb_host.sv
// tb_uart_wb_host: self-checking bench for uart_wb_host (directed + randomized
// transactions against a queue-based response model, interrupt edge counting
// from the recorded int_in history, optional timeout when UART_WB_TIMEOUT_EN).
module tb_uart_wb_host;
  import uart_wb_pkg::*;

  logic       clk = 1'b0;
  logic       rst_in = 1'b1;
  logic       cmd_valid_in = 1'b0;
  logic       cmd_ready_out;
  logic       cmd_we_in = 1'b0;
  logic [2:0] cmd_addr_in = '0;
  logic [7:0] cmd_wdata_in = '0;
  logic       rsp_valid_out;
  logic       rsp_ready_in = 1'b0;
  logic [7:0] rsp_rdata_out;
  logic       rsp_err_out;
  logic [2:0] addr_out;
  logic [7:0] data_out;
  logic [7:0] data_in = '0;
  logic [3:0] sel_out;
  logic       stb_out;
  logic       cyc_out;
  logic       wr_enb_out;
  logic       ack_in = 1'b0;
  logic       int_in = 1'b0;
  logic       irq_pending_out;
  logic [7:0] irq_count_out;

  int checks = 0;
  int errors = 0;

  rsp_t exp_q[$];
  logic irq_hist[$];

  uart_wb_host #(
    .SEL_VAL       (4'b0001),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk            (clk),
    .rst_in         (rst_in),
    .cmd_valid_in   (cmd_valid_in),
    .cmd_ready_out  (cmd_ready_out),
    .cmd_we_in      (cmd_we_in),
    .cmd_addr_in    (cmd_addr_in),
    .cmd_wdata_in   (cmd_wdata_in),
    .rsp_valid_out  (rsp_valid_out),
    .rsp_ready_in   (rsp_ready_in),
    .rsp_rdata_out  (rsp_rdata_out),
    .rsp_err_out    (rsp_err_out),
    .addr_out       (addr_out),
    .data_out       (data_out),
    .data_in        (data_in),
    .sel_out        (sel_out),
    .stb_out        (stb_out),
    .cyc_out        (cyc_out),
    .wr_enb_out     (wr_enb_out),
    .ack_in         (ack_in),
    .int_in         (int_in),
    .irq_pending_out(irq_pending_out),
    .irq_count_out  (irq_count_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input bit ok);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s", tag);
    end
  endtask

  // Rising edges of int_in over the recorded history (level 0 before it),
  // saturated at 255.
  function automatic logic [7:0] irq_model();
    int unsigned n = 0;
    logic prev = 1'b0;
    foreach (irq_hist[i]) begin
      if (irq_hist[i] && !prev) n++;
      prev = irq_hist[i];
    end
    return (n > 255) ? 8'd255 : 8'(n);
  endfunction

  task automatic irq_step(input logic v);
    int_in = v;
    irq_hist.push_back(v);
    @(negedge clk);
    check("irq_pending", irq_pending_out === v);
  endtask

  // One full command: present at a negedge, ack after 'waits' wait cycles,
  // hold the response for 'hold' cycles before consuming it. With b2b a second
  // (different) command is kept valid throughout and must not be taken.
  task automatic run_txn(input logic we, input logic [2:0] addr,
                         input logic [7:0] wdata, input logic [7:0] rd,
                         input int unsigned waits, input int unsigned hold,
                         input bit b2b, input string tag);
    rsp_t exp;
    rsp_t cur;
    exp.rdata = we ? 8'h00 : rd;
    exp.err   = 1'b0;
    exp_q.push_back(exp);

    check({tag, ":ready_idle"}, cmd_ready_out === 1'b1);
    cmd_valid_in = 1'b1;
    cmd_we_in    = we;
    cmd_addr_in  = addr;
    cmd_wdata_in = wdata;
    rsp_ready_in = 1'b0;
    @(negedge clk);
    if (b2b) begin
      cmd_we_in    = ~we;
      cmd_addr_in  = 3'(addr + 3'd1);
      cmd_wdata_in = ~wdata;
    end else begin
      cmd_valid_in = 1'b0;
    end

    for (int unsigned c = 0; c <= waits; c++) begin
      check({tag, ":stb"}, stb_out === 1'b1);
      check({tag, ":cyc"}, cyc_out === 1'b1);
      check({tag, ":addr"}, addr_out === addr);
      check({tag, ":data"}, data_out === wdata);
      check({tag, ":we"}, wr_enb_out === we);
      check({tag, ":sel"}, sel_out === 4'b0001);
      check({tag, ":ready_bus"}, cmd_ready_out === 1'b0);
      check({tag, ":valid_bus"}, rsp_valid_out === 1'b0);
      data_in = 8'($urandom);
      if (c == waits) begin
        ack_in       = 1'b1;
        data_in      = rd;
        rsp_ready_in = (hold == 0);
      end
      @(negedge clk);
    end
    ack_in  = 1'b0;
    data_in = 8'($urandom);

    check({tag, ":stb_drop"}, stb_out === 1'b0);
    check({tag, ":cyc_drop"}, cyc_out === 1'b0);
    check({tag, ":idle_bus"}, {addr_out, data_out, wr_enb_out, sel_out} === 16'h0000);

    cur = exp_q.pop_front();
    for (int unsigned h = 0; h <= hold; h++) begin
      check({tag, ":rsp_valid"}, rsp_valid_out === 1'b1);
      check({tag, ":rsp_rdata"}, rsp_rdata_out === cur.rdata);
      check({tag, ":rsp_err"}, rsp_err_out === cur.err);
      check({tag, ":ready_resp"}, cmd_ready_out === 1'b0);
      check({tag, ":stb_resp"}, stb_out === 1'b0);
      if (h == hold) rsp_ready_in = 1'b1;
      @(negedge clk);
    end
    rsp_ready_in = 1'b0;
    check({tag, ":rsp_done"}, rsp_valid_out === 1'b0);
    check({tag, ":ready_back"}, cmd_ready_out === 1'b1);
    cmd_valid_in = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset state ----
    #2 rst_in = 1'b0;
    #1;
    check("rst:ready", cmd_ready_out === 1'b0);
    check("rst:rsp", {rsp_valid_out, rsp_rdata_out, rsp_err_out} === 10'h000);
    check("rst:bus", {stb_out, cyc_out, wr_enb_out, sel_out, addr_out, data_out} === 18'h00000);
    check("rst:irq", {irq_pending_out, irq_count_out} === 9'h000);
    @(negedge clk);
    @(negedge clk);
    rst_in = 1'b1;
    @(negedge clk);
    check("rst:ready_after", cmd_ready_out === 1'b1);

    // ---- directed transactions ----
    run_txn(1'b1, LCR, 8'h83, 8'hA5, 0, 0, 1'b0, "wr_lcr");
    run_txn(1'b0, LSR, 8'h00, 8'h60, 3, 0, 1'b0, "rd_lsr");
    run_txn(1'b1, SCR, 8'h5A, 8'h00, 1, 5, 1'b1, "b2b_wr");
    run_txn(1'b0, MSR, 8'h11, 8'hC3, 2, 5, 1'b1, "b2b_rd");

    // ---- randomized transactions ----
    for (int i = 0; i < 24; i++) begin
      run_txn(1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom),
              $urandom_range(0, 4), $urandom_range(0, 3), 1'($urandom), "rand");
    end

`ifdef UART_WB_TIMEOUT_EN
    // ---- timeout: never ack ----
    check("to:ready", cmd_ready_out === 1'b1);
    cmd_valid_in = 1'b1;
    cmd_we_in    = 1'b0;
    cmd_addr_in  = IIR_FCR;
    data_in      = 8'hFF;
    @(negedge clk);
    cmd_valid_in = 1'b0;
    for (int c = 0; c < 16; c++) begin
      check("to:stb_held", stb_out === 1'b1);
      @(negedge clk);
    end
    check("to:stb_drop", {stb_out, cyc_out} === 2'b00);
    check("to:valid", rsp_valid_out === 1'b1);
    check("to:err", rsp_err_out === 1'b1);
    check("to:rdata", rsp_rdata_out === 8'h00);
    ack_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ack_in = 1'b0;
    check("to:late_ack_valid", rsp_valid_out === 1'b1);
    check("to:late_ack_err", rsp_err_out === 1'b1);
    check("to:late_ack_rdata", rsp_rdata_out === 8'h00);
    check("to:late_ack_stb", stb_out === 1'b0);
    rsp_ready_in = 1'b1;
    @(negedge clk);
    rsp_ready_in = 1'b0;
    check("to:consumed", {rsp_valid_out, cmd_ready_out} === 2'b01);
    // ack on the very edge that would time out completes normally
    run_txn(1'b0, IER, 8'h00, 8'h3C, 15, 1, 1'b0, "to_edge_ack");
`else
    // no timeout: BUS waits well beyond 16 cycles
    run_txn(1'b0, IER, 8'h00, 8'h3C, 40, 1, 1'b0, "long_wait");
`endif

    // ---- reset mid BUS ----
    cmd_valid_in = 1'b1;
    cmd_we_in    = 1'b1;
    cmd_addr_in  = MCR;
    cmd_wdata_in = 8'h0F;
    @(negedge clk);
    cmd_valid_in = 1'b0;
    check("mid_rst:in_bus", stb_out === 1'b1);
    rst_in = 1'b0;
    #1;
    check("mid_rst:stb_cyc", {stb_out, cyc_out} === 2'b00);
    check("mid_rst:rsp_valid", rsp_valid_out === 1'b0);
    check("mid_rst:bus_fields", {addr_out, data_out, wr_enb_out} === 12'h000);
    @(negedge clk);
    rst_in = 1'b1;
    ack_in = 1'b1;
    @(negedge clk);
    ack_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("mid_rst:no_rsp", rsp_valid_out === 1'b0);
      check("mid_rst:no_stb", stb_out === 1'b0);
      check("mid_rst:ready", cmd_ready_out === 1'b1);
      @(negedge clk);
    end

    // ---- interrupt tracking ----
    check("irq:start", irq_count_out === 8'd0);
    for (int i = 0; i < 2; i++) begin
      irq_step(1'b1);
      irq_step(1'b0);
    end
    for (int i = 0; i < 10; i++) irq_step(1'b1);
    check("irq:three_edges", irq_count_out === irq_model());
    for (int i = 0; i < 100; i++) irq_step(1'($urandom));
    check("irq:random", irq_count_out === irq_model());
    for (int i = 0; i < 700; i++) begin
      irq_step((i % 2 == 0) ? 1'b1 : 1'($urandom_range(0, 4) == 0));
    end
    check("irq:saturate", irq_count_out === irq_model());
    irq_step(1'b0);
    irq_step(1'b1);
    check("irq:hold_sat", irq_count_out === irq_model());
    // a transaction while interrupts are active is unaffected
    run_txn(1'b0, RBR_THR, 8'h00, 8'h7E, 1, 0, 1'b0, "irq_txn");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
